control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 5, width of the opcode field.
REQ-002 Parameter OP_LD, default 5'b00000, load-from-memory opcode.
REQ-003 Parameter OP_LDI, default 5'b00001, load-immediate opcode.
REQ-004 Parameter OP_ST, default 5'b00010, store opcode.
REQ-005 Parameter OP_ADD, default 5'b00011, register-register add opcode.
REQ-006 Parameter OP_HALT, default 5'b11011, halt opcode.
REQ-007 Parameter TIMEOUT, default 16, maximum number of wait cycles per memory access (range 1..255).
REQ-008 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-009 Port list: clock  in  1  single clock; all state changes occur on its rising edge.
REQ-010 Port list: clear  in  1  synchronous active-high reset.
REQ-011 Port list: run  in  1  permits fetching of the next instruction.
REQ-012 Port list: mem_ready  in  1  memory has completed the current read or write.
REQ-013 Port list: opcode  in  OPCODE_W  IR opcode field, valid from the state after IRin.
REQ-014 Port list: ctrl  out  21  datapath strobes; bit assignment: 0 PCout, 1 PCin, 2 IncPC, 3 MARin, 4 Read, 5 Write, 6 MD_read, 7 MDRin, 8 MDRout, 9 IRin, 10 Yin, 11 Zlowin, 12 Zlowout, 13 Gra, 14 Grb, 15 Grc, 16 Rin, 17 Rout, 18 BAout, 19 Csignout, 20 ADD.
REQ-015 Port list: state  out  4  current state encoding, for debug.
REQ-016 Port list: instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-017 Port list: halted  out  1  high while in HALTED.
REQ-018 Port list: mem_err  out  1  high while in ERROR.

Function
REQ-019 The FSM SHALL be Moore type, with registered state; ctrl SHALL be decoded only from state and latched opcode; unlisted ctrl bits SHALL be 0 in every state.
REQ-020 States and encodings: IDLE=0, T0..T7=1..8, HALTED=9, ERROR=10.
REQ-021 IDLE: ctrl=0; go to T0 when run=1, otherwise stay in IDLE.
REQ-022 Fetch, T0: PCout, MARin, IncPC, Zlowin.
REQ-023 Fetch, T1: Zlowout, PCin, Read, MD_read, MDRin.
REQ-024 Fetch, T2: MDRout, IRin.
REQ-025 T3: opcode SHALL be latched on entry to T3 and used for dispatch through end of instruction.
REQ-026 LDI: T3 Grb, BAout, Yin; T4 Csignout, ADD, Zlowin; T5 Zlowout, Gra, Rin (done).
REQ-027 LD: T3 and T4 as LDI; T5 Zlowout, MARin; T6 Read, MD_read, MDRin; T7 MDRout, Gra, Rin (done).
REQ-028 ST: T3 and T4 as LDI; T5 Zlowout, MARin; T6 Gra, Rout, MDRin (MD_read=0); T7 Write (done).
REQ-029 ADD: T3 Grb, Rout, Yin; T4 Grc, Rout, ADD, Zlowin; T5 Zlowout, Gra, Rin (done).
REQ-030 HALT: T3 asserts no strobes, then goes to HALTED; instr_done SHALL pulse in that T3 cycle.
REQ-031 Unknown opcode: treated as NOP; T3 is the done cycle.
REQ-032 After a done cycle, the next state SHALL be T0 if run=1 and IDLE if run=0.
REQ-033 Memory states are fetch T1, LD T6 and ST T7; the FSM SHALL hold the state, with ctrl unchanged, while mem_ready=0, and advance on the edge where mem_ready=1.
REQ-034 An 8-bit wait counter SHALL clear on entry to each memory state and increment on each cycle with mem_ready=0.
REQ-035 If the wait counter reaches TIMEOUT with mem_ready still 0, the next state SHALL be ERROR.
REQ-036 When mem_ready=1 arrives on the same cycle as the timeout, the advance SHALL win.
REQ-037 mem_ready SHALL be ignored in all non-memory states.
REQ-038 HALTED and ERROR SHALL be absorbing: ctrl=0 and run ignored; only clear exits them.
REQ-039 instr_done SHALL never assert in IDLE, HALTED or ERROR.

Reset
REQ-040 On a rising edge with clear=1: state=IDLE, ctrl=0, instr_done=0, halted=0, mem_err=0, and the wait counter and latched opcode are 0.
REQ-041 clear SHALL take priority over all transitions, including mid-instruction and during a memory wait; the aborted instruction SHALL NOT pulse instr_done.

Verification
REQ-042 run=1, mem_ready=1, opcode=OP_LDI -> states 1,2,3,4,5,6 then 1; ctrl in T5 = bits{12,13,16}; instr_done high 1 cycle at state=6.
REQ-043 Test: LD with mem_ready low for 3 cycles in T6.
 - Response: state=7 held 4 cycles with ctrl={4,6,7} constant, then T7 ctrl={8,13,16}.
 - Response: total instruction length 11 cycles.
REQ-044 ST then run=0 -> T7 ctrl={5}, done, then IDLE with ctrl=0; returning run=1 restarts at T0.
REQ-045 Fetch with mem_ready stuck 0, TIMEOUT=4 -> after 4 wait cycles state=10, mem_err=1, ctrl=0; clear -> IDLE next edge.
REQ-046 Test: OP_HALT, then clear asserted in the middle of a later ADD (state=5).
 - Response: after OP_HALT, state=9 and halted=1, with run toggling ignored.
 - Response: clear mid-ADD gives IDLE next edge, with no instr_done pulse.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Moore-type hardwired control unit for a small accumulator/register CPU.
// Runs the three-cycle fetch (T0..T2), latches the opcode on entry to T3 and
// then drives the datapath strobes for LD, LDI, ST, ADD and HALT. Unknown
// opcodes complete as a NOP in T3. Memory states (fetch T1, LD T6, ST T7)
// stall on mem_ready and fall into ERROR if the memory never answers within
// TIMEOUT wait cycles.
//
// Ports
//   clock      in   1         single clock, rising-edge
//   clear      in   1         synchronous active-high reset
//   run        in   1         permits fetching of the next instruction
//   mem_ready  in   1         memory completed the current read/write
//   opcode     in   OPCODE_W  IR opcode field
//   ctrl       out  21        datapath strobes (bit map in localparams below)
//   state      out  4         current state encoding (debug)
//   instr_done out  1         pulse in the final cycle of each instruction
//   halted     out  1         high while in HALTED
//   mem_err    out  1         high while in ERROR
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int                  OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] OP_LD    = 5'b00000,
  parameter logic [OPCODE_W-1:0] OP_LDI   = 5'b00001,
  parameter logic [OPCODE_W-1:0] OP_ST    = 5'b00010,
  parameter logic [OPCODE_W-1:0] OP_ADD   = 5'b00011,
  parameter logic [OPCODE_W-1:0] OP_HALT  = 5'b11011,
  parameter int                  TIMEOUT  = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [20:0]         ctrl,
  output logic [3:0]          state,
  output logic                instr_done,
  output logic                halted,
  output logic                mem_err
);

  // Strobe bit positions within ctrl.
  localparam int PC_OUT   = 0;
  localparam int PC_IN    = 1;
  localparam int INC_PC   = 2;
  localparam int MAR_IN   = 3;
  localparam int READ     = 4;
  localparam int WRITE    = 5;
  localparam int MD_READ  = 6;
  localparam int MDR_IN   = 7;
  localparam int MDR_OUT  = 8;
  localparam int IR_IN    = 9;
  localparam int Y_IN     = 10;
  localparam int ZLOW_IN  = 11;
  localparam int ZLOW_OUT = 12;
  localparam int GRA      = 13;
  localparam int GRB      = 14;
  localparam int GRC      = 15;
  localparam int R_IN     = 16;
  localparam int R_OUT    = 17;
  localparam int BA_OUT   = 18;
  localparam int CSIGNOUT = 19;
  localparam int ALU_ADD  = 20;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9,
    S_ERROR  = 4'd10
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [OPCODE_W-1:0] op_q, op_d;

  logic is_mem;       // current state waits on mem_ready
  logic is_done;      // current state is the last one of the instruction
  logic advance;
  logic timeout_hit;

  // Strobe decode: a pure function of state and latched opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case statements can infer a latch.
    ctrl    = '0;
    is_mem  = 1'b0;
    is_done = 1'b0;
    case (state_q)
      S_T0: begin
        ctrl[PC_OUT] = 1'b1; ctrl[MAR_IN]  = 1'b1;
        ctrl[INC_PC] = 1'b1; ctrl[ZLOW_IN] = 1'b1;
      end
      S_T1: begin
        ctrl[ZLOW_OUT] = 1'b1; ctrl[PC_IN]  = 1'b1; ctrl[READ] = 1'b1;
        ctrl[MD_READ]  = 1'b1; ctrl[MDR_IN] = 1'b1;
        is_mem = 1'b1;
      end
      S_T2: begin
        ctrl[MDR_OUT] = 1'b1; ctrl[IR_IN] = 1'b1;
      end
      S_T3: begin
        case (op_q)
          OP_LD, OP_LDI, OP_ST: begin
            ctrl[GRB] = 1'b1; ctrl[BA_OUT] = 1'b1; ctrl[Y_IN] = 1'b1;
          end
          OP_ADD: begin
            ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Y_IN] = 1'b1;
          end
          default: is_done = 1'b1;  // HALT and unknown opcodes end here
        endcase
      end
      S_T4: begin
        case (op_q)
          OP_LD, OP_LDI, OP_ST: begin
            ctrl[CSIGNOUT] = 1'b1; ctrl[ALU_ADD] = 1'b1; ctrl[ZLOW_IN] = 1'b1;
          end
          OP_ADD: begin
            ctrl[GRC] = 1'b1; ctrl[R_OUT] = 1'b1;
            ctrl[ALU_ADD] = 1'b1; ctrl[ZLOW_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_q)
          OP_LDI, OP_ADD: begin
            ctrl[ZLOW_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
            is_done = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctrl[ZLOW_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_q)
          OP_LD: begin
            ctrl[READ] = 1'b1; ctrl[MD_READ] = 1'b1; ctrl[MDR_IN] = 1'b1;
            is_mem = 1'b1;
          end
          OP_ST: begin
            // MD_read stays low so MDR captures the bus, not memory.
            ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[MDR_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_q)
          OP_LD: begin
            ctrl[MDR_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
            is_done = 1'b1;
          end
          OP_ST: begin
            ctrl[WRITE] = 1'b1;
            is_mem  = 1'b1;
            is_done = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;  // IDLE, HALTED, ERROR drive nothing
    endcase
  end

  // Memory states only move on when mem_ready is seen; a ready arriving on
  // the timeout cycle still advances because timeout_hit requires !mem_ready.
  assign advance     = !is_mem || mem_ready;
  assign timeout_hit = is_mem && !mem_ready && (wait_q >= 8'(TIMEOUT - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    // The counter is zero whenever we are not stalled, so it is already
    // cleared on entry to every memory state.
    wait_d  = '0;
    if (is_mem && !mem_ready) wait_d = wait_q + 8'd1;
    if (state_q == S_T2) op_d = opcode;

    case (state_q)
      S_IDLE:            if (run) state_d = S_T0;
      S_HALTED, S_ERROR: state_d = state_q;
      default: begin
        if (timeout_hit) begin
          state_d = S_ERROR;
        end else if (advance) begin
          if (state_q == S_T3 && op_q == OP_HALT) state_d = S_HALTED;
          else if (is_done)                       state_d = run ? S_T0 : S_IDLE;
          else                                    state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  assign state      = state_q;
  assign instr_done = is_done && advance;
  assign halted     = (state_q == S_HALTED);
  assign mem_err    = (state_q == S_ERROR);

endmodule
